homomorphic_addsub_stream: RTL

//  Streaming LWE ciphertext add/subtract engine. Accepts two ciphertexts as beats of PARALLEL

---
 rtl/homomorphic_addsub_stream_pkg.sv | 16 +
 rtl/homomorphic_addsub_stream_lane.sv | 52 +++++
 rtl/homomorphic_addsub_stream.sv | 106 ++++++++++
 3 files changed

// File: rtl/homomorphic_addsub_stream_pkg.sv
// homomorphic_pkg: shared operation encoding and framing helpers for the LWE add/sub stream.
package homomorphic_pkg;

    typedef enum logic {
        HOM_ADD = 1'b0,
        HOM_SUB = 1'b1
    } hom_op_e;

    localparam int HOM_CT_COUNT_W = 16;

    // ceil((dim+1)/par): a ciphertext carries dim+1 coefficients spread over par lanes
    function automatic int beats_per_ct(input int dim, input int par);
        return (dim + par) / par;
    endfunction

endpackage

// File: rtl/homomorphic_addsub_stream_lane.sv
// mod_addsub_lane: one coefficient lane; S1 holds the raw CW+1-bit sum/difference,
// S2 holds the modular correction, with lanes beyond the ciphertext forced to zero.
module mod_addsub_lane #(
    parameter int CW = 10,
    parameter int Q  = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en1,
    input  logic          i_en2,
    input  logic          i_op,
    input  logic          i_pad,
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    output logic [CW-1:0] o_r,
    output logic          o_noncanon
);
    localparam logic [CW:0] QW = (CW + 1)'(Q);

    logic [CW:0]   w_a;
    logic [CW:0]   w_b;
    logic [CW:0]   r_raw;
    logic          r_op;
    logic          r_pad;
    logic [CW-1:0] w_fix;
    logic [CW-1:0] r_res;

    assign w_a        = {1'b0, i_a};
    assign w_b        = {1'b0, i_b};
    assign o_noncanon = (w_a >= QW) || (w_b >= QW);
    // a negative difference borrows into bit CW; adding q wraps it back into [0,q-1]
    assign w_fix = r_op ? (r_raw[CW] ? CW'(r_raw + QW) : r_raw[CW-1:0])
                        : ((r_raw >= QW) ? CW'(r_raw - QW) : r_raw[CW-1:0]);
    assign o_r   = r_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw <= '0;
            r_op  <= 1'b0;
            r_pad <= 1'b0;
            r_res <= '0;
        end else begin
            if (i_en1) begin
                r_raw <= i_op ? (w_a - w_b) : (w_a + w_b);
                r_op  <= i_op;
                r_pad <= i_pad;
            end
            if (i_en2) r_res <= r_pad ? '0 : w_fix;
        end
    end

endmodule

// File: rtl/homomorphic_addsub_stream.sv
// homomorphic_addsub_stream: framed, flow-controlled LWE ciphertext add/subtract mod q.
// Owns the handshake, beat framing, op latching and status flags; lanes do the arithmetic.
module homomorphic_addsub_stream
    import homomorphic_pkg::*;
#(
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 10,
    parameter int DIMENSION          = 1,
    parameter int PARALLEL           = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_op,
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] ciphertext1,
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] ciphertext2,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] result,
    output logic                                 out_last,
    output logic                                 err_noncanon,
    output logic [15:0]                          ct_count
);
    localparam int CW    = CIPHERTEXT_WIDTH;
    localparam int BEATS = beats_per_ct(DIMENSION, PARALLEL);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [BW-1:0]             r_beat;
    hom_op_e                   r_op;
    logic                      r_v1;
    logic                      r_last1;
    logic                      r_v2;
    logic                      r_last2;
    logic                      r_err;
    logic [HOM_CT_COUNT_W-1:0] r_ct;
    logic                      w_adv;
    logic                      w_fire;
    logic                      w_first;
    logic                      w_final;
    logic                      w_sub;
    logic [PARALLEL-1:0]       w_nc;
    logic [PARALLEL-1:0]       w_pad;

    assign w_adv        = !r_v2 || out_ready;
    assign in_ready     = rst_n && w_adv;
    assign w_fire       = in_valid && in_ready;
    assign w_first      = (r_beat == '0);
    assign w_final      = (r_beat == LAST_BEAT);
    // the op is sampled at frame start only; later beats reuse the latched value
    assign w_sub        = w_first ? in_op : (r_op == HOM_SUB);
    assign out_valid    = r_v2;
    assign out_last     = r_last2;
    assign err_noncanon = r_err;
    assign ct_count     = r_ct;

    for (genvar i = 0; i < PARALLEL; i++) begin : g_lane
        localparam bit PAD = ((BEATS - 1) * PARALLEL + i) >= (DIMENSION + 1);
        logic w_nc_raw;
        assign w_pad[i] = w_final && PAD;
        assign w_nc[i]  = w_nc_raw && !w_pad[i];
        mod_addsub_lane #(
            .CW(CW),
            .Q (CIPHERTEXT_MODULUS)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_en1     (w_fire),
            .i_en2     (w_adv && r_v1),
            .i_op      (w_sub),
            .i_pad     (w_pad[i]),
            .i_a       (ciphertext1[i*CW +: CW]),
            .i_b       (ciphertext2[i*CW +: CW]),
            .o_r       (result[i*CW +: CW]),
            .o_noncanon(w_nc_raw)
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat  <= '0;
            r_op    <= HOM_ADD;
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_err   <= 1'b0;
            r_ct    <= '0;
        end else begin
            if (w_fire) begin
                r_beat <= w_final ? '0 : r_beat + BW'(1);
                if (w_first) r_op <= hom_op_e'(in_op);
            end
            if (w_adv) begin
                r_v1    <= w_fire;
                r_last1 <= w_fire && w_final;
                r_v2    <= r_v1;
                r_last2 <= r_v1 && r_last1;
            end
            if (w_fire && |w_nc) r_err <= 1'b1;
            if (r_v2 && out_ready && r_last2) r_ct <= r_ct + 16'd1;
        end
    end

endmodule
